// File: rtl/weight_pkg.sv
// Shared types and layer presets for the weight-row streamer.
package weight_pkg;

    localparam int DATA_W   = 32;

    localparam int L0_LANES = 128;
    localparam int L0_ROWS  = 784;
    localparam int L1_LANES = 10;
    localparam int L1_ROWS  = 128;

    typedef enum logic [1:0] {IDLE, RUN, DONE} ws_state_t;

    // Built-in test pattern word: row number in the upper half, lane index in the lower half.
    function automatic logic [31:0] test_word(input logic [31:0] row, input logic [31:0] lane);
        return (row << 16) | lane;
    endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// Two-entry skid FIFO. Entry 0 is always the head, so the head output is a
// plain register and stays stable until it is popped.
module weight_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clka,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;

    assign head = slot0;

    // Storage and occupancy; pop shifts entry 1 forward, push fills the first free entry.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= din;
                    end else begin
                        slot0 <= din;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= din;
                    end else begin
                        slot1 <= din;
                    end
                    count <= count + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_streamer.sv
// Weight-row streamer: reads row_count consecutive rows from a synchronous
// weight memory starting at base_row and streams one row per beat.
// Optional build macro WEIGHT_STREAMER_TESTPAT_EN replaces memory data with
// the generated pattern (row << 16) | lane while keeping all timing.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing reads and delivering beats
// DONE  | one-cycle completion pulse
module weight_streamer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 128,
    parameter int DEPTH  = 784,
    parameter int ROW_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                           clka,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic [ROW_W-1:0]               base_row,
    input  logic [CNT_W-1:0]               row_count,
    output logic                           busy,
    output logic                           done,
    output logic                           mem_en,
    output logic [ROW_W-1:0]               mem_addr,
    input  logic [LANES*DATA_W-1:0]        mem_rdata,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [LANES-1:0][DATA_W-1:0]   out_data,
    output logic [ROW_W-1:0]               out_row,
    output logic                           out_last
);

    import weight_pkg::*;

    localparam int DW_ROW = LANES * DATA_W;
    localparam int FW     = DW_ROW + ROW_W + 1;

    ws_state_t          state_q, state_d;
    logic [ROW_W-1:0]   addr_q;
    logic [CNT_W-1:0]   issued_q;
    logic [CNT_W-1:0]   total_q;
    logic               infl_q;
    logic [ROW_W-1:0]   infl_row_q;
    logic               infl_last_q;

    logic [CNT_W-1:0]   req_count;
    logic [2:0]         occ;
    logic               accept;
    logic               issue;
    logic               pop;
    logic [1:0]         fifo_count;
    logic [FW-1:0]      push_word;
    logic [FW-1:0]      head;
    logic [DW_ROW-1:0]  row_data;

    assign req_count = (row_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : row_count;
    assign accept    = (state_q == IDLE) && start && !abort;
    assign pop       = out_valid & out_ready;
    // Slots already committed: queued beats plus the read in flight, less the one leaving now.
    assign occ       = 3'(fifo_count) + 3'(infl_q) - 3'(pop);
    assign issue     = (state_q == RUN) && !abort && (issued_q < total_q) && (occ < 3'd2);

    assign mem_en    = issue;
    assign mem_addr  = addr_q;

    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = head[DW_ROW-1:0];
    assign out_row   = head[DW_ROW +: ROW_W];
    assign out_last  = head[FW-1];

`ifdef WEIGHT_STREAMER_TESTPAT_EN
    // Pattern row for the read in flight; memory data is not used.
    always_comb begin
        row_data = '0;
        for (int i = 0; i < LANES; i++) begin
            row_data[i*DATA_W +: DATA_W] = DATA_W'(test_word(32'(infl_row_q), 32'(i)));
        end
    end
`else
    assign row_data = mem_rdata;
`endif

    assign push_word = {infl_last_q, infl_row_q, row_data};

    // State register.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and status outputs; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (row_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (pop && out_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Job registers, address walk with wrap, and the one-deep in-flight read tag.
    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            issued_q    <= '0;
            total_q     <= '0;
            infl_q      <= 1'b0;
            infl_row_q  <= '0;
            infl_last_q <= 1'b0;
        end else begin
            infl_q <= issue;
            if (issue) begin
                infl_row_q  <= addr_q;
                infl_last_q <= (issued_q == total_q - CNT_W'(1));
            end
            if (accept) begin
                addr_q   <= base_row;
                issued_q <= '0;
                total_q  <= req_count;
            end else if (issue) begin
                addr_q   <= (addr_q == ROW_W'(DEPTH - 1)) ? '0 : addr_q + ROW_W'(1);
                issued_q <= issued_q + CNT_W'(1);
            end
        end
    end

    weight_skid_fifo #(
        .W (FW)
    ) u_fifo (
        .clka  (clka),
        .rst   (rst),
        .push  (infl_q && !abort),
        .pop   (pop),
        .flush (abort),
        .din   (push_word),
        .count (fifo_count),
        .head  (head)
    );

endmodule

// File: tb/tb_weight_streamer.sv
// Directed bench for weight_streamer using the layer-1 geometry (10 lanes, 128 rows).
// The memory model returns the same (row << 16) | lane pattern the test-pattern build generates.
module tb_weight_streamer;

    localparam int DW = 32;
    localparam int LN = 10;
    localparam int DP = 128;
    localparam int RW = $clog2(DP);
    localparam int CW = $clog2(DP + 1);

    logic                    clka = 1'b0;
    logic                    rst = 1'b1;
    logic                    start = 1'b0;
    logic                    abort = 1'b0;
    logic [RW-1:0]           base_row = '0;
    logic [CW-1:0]           row_count = '0;
    logic                    busy;
    logic                    done;
    logic                    mem_en;
    logic [RW-1:0]           mem_addr;
    logic [LN*DW-1:0]        mem_rdata = '0;
    logic                    out_valid;
    logic                    out_ready = 1'b0;
    logic [LN-1:0][DW-1:0]   out_data;
    logic [RW-1:0]           out_row;
    logic                    out_last;

    int errors = 0;
    int checks = 0;
    int max_fill = 0;
    int ft;
    int tt;

    weight_streamer #(
        .DATA_W (DW),
        .LANES  (LN),
        .DEPTH  (DP)
    ) dut (
        .clka      (clka),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_row  (base_row),
        .row_count (row_count),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    always #5 clka = ~clka;

    function automatic logic [LN*DW-1:0] exp_row(input int r);
        logic [LN*DW-1:0] v;
        v = '0;
        for (int i = 0; i < LN; i++) begin
            v[i*DW +: DW] = 32'((r << 16) | i);
        end
        return v;
    endfunction

    // Synchronous-read weight memory model.
    always @(posedge clka) begin
        if (mem_en) mem_rdata <= exp_row(int'(mem_addr));
    end

    // Track the deepest FIFO occupancy seen.
    always @(negedge clka) begin
        if (int'(dut.u_fifo.count) > max_fill) max_fill = int'(dut.u_fifo.count);
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input int b, input int c);
        base_row  = RW'(b);
        row_count = CW'(c);
        start     = 1'b1;
        @(negedge clka);
        start     = 1'b0;
    endtask

    // Consume beats k0..k_end-1 of a job; t counts negedges since the start edge.
    task automatic collect(input int b, input int n_total, input int k0, input int k_end,
                           input bit rnd, output int first_t, output int t_out);
        int k;
        int t;
        int r;
        bit stalled;
        k = k0;
        t = 0;
        stalled = 1'b0;
        first_t = -1;
        while (k < k_end && t < 3000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) chk("hold_valid", 512'(out_valid), 512'(1));
            if (out_valid) begin
                if (first_t < 0) first_t = t;
                r = (b + k) % DP;
                chk("out_row", 512'(out_row), 512'(r));
                chk("out_data", 512'(out_data), 512'(exp_row(r)));
                chk("out_last", 512'(out_last), 512'(k == n_total - 1));
                if (out_ready) k++;
            end
            stalled = out_valid && !out_ready;
            t++;
            @(negedge clka);
        end
        chk("beat_count", 512'(k), 512'(k_end));
        t_out = t;
    endtask

    task automatic finish_job();
        chk("done_pulse", 512'(done), 512'(1));
        chk("done_busy", 512'(busy), 512'(0));
        chk("done_valid", 512'(out_valid), 512'(0));
        @(negedge clka);
        chk("done_clear", 512'(done), 512'(0));
        chk("idle_busy", 512'(busy), 512'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 512'(busy), 512'(0));
        chk({tag, "_done"}, 512'(done), 512'(0));
        chk({tag, "_mem_en"}, 512'(mem_en), 512'(0));
        chk({tag, "_mem_addr"}, 512'(mem_addr), 512'(0));
        chk({tag, "_out_valid"}, 512'(out_valid), 512'(0));
        chk({tag, "_out_data"}, 512'(out_data), 512'(0));
        chk({tag, "_out_row"}, 512'(out_row), 512'(0));
        chk({tag, "_out_last"}, 512'(out_last), 512'(0));
        chk({tag, "_state"}, 512'(dut.state_q), 512'(weight_pkg::IDLE));
    endtask

    initial begin
        repeat (2) @(negedge clka);
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clka);

        // Full memory sweep with ready held high.
        start_job(0, 128);
        chk("t1_busy", 512'(busy), 512'(1));
        chk("t1_mem_en", 512'(mem_en), 512'(1));
        chk("t1_mem_addr", 512'(mem_addr), 512'(0));
        chk("t1_valid_e0", 512'(out_valid), 512'(0));
        collect(0, 128, 0, 128, 1'b0, ft, tt);
        chk("t1_latency", 512'(ft), 512'(2));
        chk("t1_back_to_back", 512'(tt), 512'(2 + 128));
        finish_job();

        // Wrap from row 127 back to row 0.
        start_job(120, 16);
        chk("t2_mem_addr", 512'(mem_addr), 512'(120));
        collect(120, 16, 0, 16, 1'b0, ft, tt);
        chk("t2_latency", 512'(ft), 512'(2));
        chk("t2_back_to_back", 512'(tt), 512'(2 + 16));
        finish_job();

        // Random backpressure.
        start_job(30, 40);
        collect(30, 40, 0, 40, 1'b1, ft, tt);
        finish_job();
        chk("fifo_max_le2", 512'(max_fill <= 2), 512'(1));

        // Zero-length job.
        start_job(9, 0);
        chk("t4_done", 512'(done), 512'(1));
        chk("t4_busy", 512'(busy), 512'(0));
        chk("t4_mem_en", 512'(mem_en), 512'(0));
        chk("t4_valid", 512'(out_valid), 512'(0));
        @(negedge clka);
        chk("t4_done_clear", 512'(done), 512'(0));
        chk("t4_mem_en2", 512'(mem_en), 512'(0));
        chk("t4_valid2", 512'(out_valid), 512'(0));

        // Oversized count clamps to the memory depth.
        start_job(5, 200);
        collect(5, 128, 0, 128, 1'b0, ft, tt);
        chk("t5_back_to_back", 512'(tt), 512'(2 + 128));
        finish_job();

        // Abort after 10 beats, then restart at row 3.
        start_job(50, 100);
        collect(50, 100, 0, 10, 1'b0, ft, tt);
        abort = 1'b1;
        out_ready = 1'b0;
        @(negedge clka);
        abort = 1'b0;
        chk("t6_valid", 512'(out_valid), 512'(0));
        chk("t6_busy", 512'(busy), 512'(0));
        chk("t6_done", 512'(done), 512'(0));
        chk("t6_mem_en", 512'(mem_en), 512'(0));
        @(negedge clka);
        chk("t6_done2", 512'(done), 512'(0));
        chk("t6_valid2", 512'(out_valid), 512'(0));
        start_job(3, 4);
        chk("t6_restart_addr", 512'(mem_addr), 512'(3));
        collect(3, 4, 0, 4, 1'b0, ft, tt);
        finish_job();

        // Start together with abort in IDLE is ignored.
        base_row = RW'(0);
        row_count = CW'(5);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clka);
        start = 1'b0;
        abort = 1'b0;
        chk("t6b_busy", 512'(busy), 512'(0));
        chk("t6b_done", 512'(done), 512'(0));
        @(negedge clka);
        chk("t6b_valid", 512'(out_valid), 512'(0));

        // Start during RUN is ignored.
        start_job(10, 20);
        collect(10, 20, 0, 5, 1'b0, ft, tt);
        out_ready = 1'b0;
        base_row = RW'(100);
        row_count = CW'(5);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        chk("t7_busy", 512'(busy), 512'(1));
        collect(10, 20, 5, 20, 1'b0, ft, tt);
        finish_job();

        // Asynchronous reset mid-job.
        start_job(0, 50);
        collect(0, 50, 0, 5, 1'b0, ft, tt);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(negedge clka);
        rst = 1'b0;
        out_ready = 1'b1;
        chk("t8_done", 512'(done), 512'(0));
        @(negedge clka);
        chk("t8_valid", 512'(out_valid), 512'(0));
        chk("t8_done2", 512'(done), 512'(0));
        start_job(7, 3);
        collect(7, 3, 0, 3, 1'b0, ft, tt);
        chk("t8_latency", 512'(ft), 512'(2));
        finish_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
